// File: rtl/cpu_uart_tx.sv
// cpu_uart_tx: buffers 16-bit CPU result words in a small FIFO and sends each
// word as two 8N1 UART frames, low byte first, on a registered TX line.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line high, waiting for a queued word
// START | start bit (line low) for the current byte
// DATA  | eight data bits of the current byte, LSB first
// STOP  | stop bit (line high); then next byte, next word, or IDLE
module cpu_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        overflow,
  output logic        tx,
  output logic        busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW:0]   DEPTH_C  = FIFO_DEPTH[PW:0];
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          fifo_empty;
  logic          push_ok;
  logic          pop;

  // Transmit datapath
  state_t        state;
  state_t        state_n;
  logic [15:0]   shift;
  logic [15:0]   shift_n;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_n;
  logic          byte_sel;
  logic          byte_sel_n;
  logic [BW-1:0] baud_cnt;
  logic [BW-1:0] baud_n;
  logic          tx_d;
  logic          baud_done;

  // A push is judged against the count before the edge, so a full FIFO
  // drops the word even if the FSM pops in the same cycle.
  assign fifo_empty = (count == '0);
  assign push_ok    = data_valid && (count < DEPTH_C);
  assign data_ready = (count < DEPTH_C);
  assign busy       = (state != IDLE) || !fifo_empty;
  assign baud_done  = (baud_cnt == BAUD_MAX);

  // FIFO word storage; stale contents are harmless once the pointers reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers, occupancy count and the registered overflow pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= data_valid && !push_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state and datapath registers; tx is registered from the next state
  // so the line changes on the same edge as the state it reflects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      byte_sel <= 1'b0;
      baud_cnt <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      bit_cnt  <= bit_n;
      byte_sel <= byte_sel_n;
      baud_cnt <= baud_n;
      tx       <= tx_d;
    end
  end

  // Next-state, pop request and next line level.
  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_n      = bit_cnt;
    byte_sel_n = byte_sel;
    baud_n     = baud_cnt;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        baud_n = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_n    = mem[rd_ptr];
          byte_sel_n = 1'b0;
          bit_n      = '0;
          state_n    = START;
        end
      end

      START: begin
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      STOP: begin
        if (baud_done) begin
          baud_n = '0;
          if (!byte_sel) begin
            byte_sel_n = 1'b1;
            state_n    = START;
          end else if (!fifo_empty) begin
            // Next word follows with no idle gap on the line.
            pop        = 1'b1;
            shift_n    = mem[rd_ptr];
            byte_sel_n = 1'b0;
            bit_n      = '0;
            state_n    = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        baud_n  = '0;
      end
    endcase

    case (state_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_n[{byte_sel_n, bit_n}];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_cpu_uart_tx.sv
// tb_cpu_uart_tx: directed stimulus with a byte scoreboard fed by a UART
// receiver model on the tx line.
module tb_cpu_uart_tx;

  localparam int C = 4;
  localparam int D = 4;

  logic        clk;
  logic        reset;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic        overflow;
  logic        tx;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  int         starts[$];

  cpu_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overflow   (overflow),
    .tx         (tx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Receiver model: sample each bit in its second cycle, check the stop bit
  // and compare the byte against the head of the scoreboard.
  int         rx_cnt = -1;
  logic [7:0] rx_byte;
  always @(negedge clk) begin
    if (!reset) begin
      rx_cnt = -1;
    end else if (rx_cnt < 0) begin
      if (tx === 1'b0) begin
        rx_cnt = 0;
        starts.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt % C) == 1 && (rx_cnt / C) >= 1 && (rx_cnt / C) <= 8)
        rx_byte[(rx_cnt / C) - 1] = tx;
      if (rx_cnt == 9 * C + 1) begin
        chk("stop_bit", {31'd0, tx}, 32'd1);
        chk("frame_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
      end
      if (rx_cnt == 10 * C - 1) rx_cnt = -1;
    end
  end

  // Drive one push strobe across the next rising edge; called #1 after an edge.
  task automatic push(input logic [15:0] w, input bit acc);
    data_in    = w;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    if (acc) begin
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
    end
  endtask

  task automatic wait_idle(input int bound);
    int i = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && i < bound) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("idle_within_bound", {31'd0, i < bound}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_gaps(input string tag, input int s0, input int nfr);
    chk({tag, "_frames"}, starts.size() - s0, nfr);
    if (starts.size() - s0 == nfr)
      for (int i = 1; i < nfr; i++)
        chk({tag, "_gap"}, starts[s0 + i] - starts[s0 + i - 1], 10 * C);
  endtask

  initial begin
    int s0;
    reset      = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_data_ready", {31'd0, data_ready}, 32'd1);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single word: latency, 80-cycle occupancy, byte content via receiver.
    push(16'hA55A, 1'b1);
    chk("latency_tx_still_high", {31'd0, tx}, 32'd1);
    @(posedge clk);
    #1;
    chk("first_start_low", {31'd0, tx}, 32'd0);
    chk("busy_after_pop", {31'd0, busy}, 32'd1);
    for (int i = 1; i < 20 * C; i++) begin
      @(posedge clk);
      #1;
      chk("busy_during_word", {31'd0, busy}, 32'd1);
    end
    @(posedge clk);
    #1;
    chk("busy_falls_after_word", {31'd0, busy}, 32'd0);
    chk("tx_idle_after_word", {31'd0, tx}, 32'd1);
    wait_idle(50);

    // Back-to-back words: six gapless frames in order.
    s0 = starts.size();
    push(16'h0001, 1'b1);
    push(16'h8000, 1'b1);
    push(16'hFFFF, 1'b1);
    wait_idle(3 * 20 * C + 50);
    chk_gaps("b2b", s0, 6);

    // Overflow: w0 is popped after one cycle, w1..w4 fill the FIFO, w5 dropped.
    s0 = starts.size();
    push(16'h1111, 1'b1);
    push(16'h2222, 1'b1);
    push(16'h3333, 1'b1);
    push(16'h4444, 1'b1);
    chk("ready_before_full", {31'd0, data_ready}, 32'd1);
    push(16'h5555, 1'b1);
    chk("ready_low_when_full", {31'd0, data_ready}, 32'd0);
    chk("no_overflow_yet", {31'd0, overflow}, 32'd0);
    push(16'h6666, 1'b0);
    chk("overflow_pulse", {31'd0, overflow}, 32'd1);
    chk("ready_still_low", {31'd0, data_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("overflow_one_cycle", {31'd0, overflow}, 32'd0);
    wait_idle(5 * 20 * C + 50);
    chk_gaps("ovf", s0, 10);

    // Wrap-around: ten words spaced 60 cycles, FIFO never fills.
    for (int k = 0; k < 10; k++) begin
      push(16'h1000 + 16'(k) * 16'h0111, 1'b1);
      repeat (59) @(posedge clk);
      #1;
    end
    wait_idle(10 * 20 * C);

    // Push coinciding with the pop at the end of a word's final stop bit.
    s0 = starts.size();
    push(16'hC0DE, 1'b1);
    push(16'hBEAD, 1'b1);
    repeat (20 * C - 1) @(posedge clk);
    #1;
    push(16'hF00D, 1'b1);
    chk("simul_no_overflow", {31'd0, overflow}, 32'd0);
    chk("simul_next_start", {31'd0, tx}, 32'd0);
    chk("simul_ready", {31'd0, data_ready}, 32'd1);
    wait_idle(3 * 20 * C + 50);
    chk_gaps("simul", s0, 6);

    // Reset during DATA of the first byte.
    push(16'hBEEF, 1'b1);
    repeat (2 * C + 2) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, data_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 30 * C; i++) begin
      @(posedge clk);
      #1;
      chk("no_residual_frame", {31'd0, tx}, 32'd1);
    end
    push(16'h1234, 1'b1);
    wait_idle(20 * C + 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
